// File: rtl/stepper_seq_pkg.sv
// Shared types and constants for the stepper move sequencer.
// Move bundle, FSM states and period clamping helper.
package stepper_seq_pkg;

   localparam int STEP_W_DEF = 16;
   localparam int PER_W_DEF  = 16;
   localparam int MIN_PERIOD = 2;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      RUN
   } state_t;

   typedef struct packed {
      logic                  dir;
      logic [STEP_W_DEF-1:0] steps;
      logic [PER_W_DEF-1:0]  period;
   } move_t;

   function automatic logic [PER_W_DEF-1:0] clamp_period(
      input logic [PER_W_DEF-1:0] p
   );
      if (p < PER_W_DEF'(MIN_PERIOD))
         return PER_W_DEF'(MIN_PERIOD);
      return p;
   endfunction

endpackage

// File: rtl/stepper_move_sequencer_step_timer.sv
// Loadable down-counter that ticks at zero and reloads.
// Load wins over counting so a new move can restart the cadence.
module step_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic [W-1:0] reload,
   output logic         tick
);

   logic [W-1:0] cnt;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en)
         cnt <= (cnt == '0) ? reload : cnt - 1'b1;
   end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Command-driven move sequencer for the 4-phase stepper driver.
// One active move plus one pending slot for gapless chaining.
module stepper_move_sequencer
   import stepper_seq_pkg::*;
#(
   parameter int STEP_W    = STEP_W_DEF,
   parameter int PER_W     = PER_W_DEF,
   parameter int SETUP_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [PER_W-1:0]  cmd_period,
   input  logic              abort,
   output logic              motor_en,
   output logic              motor_dir,
   output logic              step_tick,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] steps_left
);

   localparam int SC_W = $clog2(SETUP_CYC + 1);

   state_t          state, state_n;
   move_t           act, act_n;
   move_t           pend, pend_n;
   move_t           in_mv;
   logic            pend_valid, pend_valid_n;
   logic            dir_r, dir_n;
   logic [SC_W-1:0] sc, sc_n;
   logic            done_r, done_n;
   logic            accept;
   logic            tmr_load, tmr_en, tmr_tick;
   logic [PER_W-1:0] tmr_val;

   assign cmd_ready  = !pend_valid && !abort;
   assign accept     = cmd_valid && cmd_ready;
   assign motor_en   = (state != IDLE);
   assign motor_dir  = dir_r;
   assign busy       = (state != IDLE) || pend_valid;
   assign done       = done_r;
   assign steps_left = STEP_W'(act.steps);
   assign step_tick  = tmr_tick;
   assign tmr_en     = (state == RUN) && !abort;

   always_comb begin
      in_mv.dir    = cmd_dir;
      in_mv.steps  = STEP_W_DEF'(cmd_steps);
      in_mv.period = clamp_period(PER_W_DEF'(cmd_period));
   end

   always_comb begin
      state_n      = state;
      act_n        = act;
      pend_n       = pend;
      pend_valid_n = pend_valid;
      dir_n        = dir_r;
      sc_n         = sc;
      done_n       = 1'b0;
      tmr_load     = 1'b0;
      tmr_val      = PER_W'(act.period - 1'b1);
      if (abort) begin
         state_n      = IDLE;
         pend_valid_n = 1'b0;
         act_n.steps  = '0;
      end else begin
         if (accept && state != IDLE) begin
            pend_n       = in_mv;
            pend_valid_n = 1'b1;
         end
         unique case (state)
            IDLE: begin
               // a command parked at end-of-move is launched from here
               if (pend_valid) begin
                  pend_valid_n = 1'b0;
                  if (pend.steps != '0) begin
                     act_n   = pend;
                     dir_n   = pend.dir;
                     sc_n    = '0;
                     state_n = SETUP;
                  end else begin
                     done_n = 1'b1;
                  end
               end else if (accept) begin
                  if (in_mv.steps != '0) begin
                     act_n   = in_mv;
                     dir_n   = in_mv.dir;
                     sc_n    = '0;
                     state_n = SETUP;
                  end else begin
                     done_n = 1'b1;
                  end
               end
            end
            SETUP: begin
               sc_n = sc + 1'b1;
               if (sc == SC_W'(SETUP_CYC - 1)) begin
                  state_n  = RUN;
                  tmr_load = 1'b1;
                  tmr_val  = PER_W'(act.period - 1'b1);
               end
            end
            RUN: begin
               if (tmr_tick) begin
                  act_n.steps = act.steps - 1'b1;
                  if (act.steps == STEP_W_DEF'(1)) begin
                     if (pend_valid && pend.steps != '0) begin
                        act_n        = pend;
                        pend_valid_n = 1'b0;
                        if (pend.dir == act.dir) begin
                           tmr_load = 1'b1;
                           tmr_val  = PER_W'(pend.period - 1'b1);
                        end else begin
                           dir_n   = pend.dir;
                           sc_n    = '0;
                           state_n = SETUP;
                        end
                     end else begin
                        if (pend_valid)
                           pend_valid_n = 1'b0;
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end
                  end
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         act        <= '0;
         pend       <= '0;
         pend_valid <= 1'b0;
         dir_r      <= 1'b0;
         sc         <= '0;
         done_r     <= 1'b0;
      end else begin
         state      <= state_n;
         act        <= act_n;
         pend       <= pend_n;
         pend_valid <= pend_valid_n;
         dir_r      <= dir_n;
         sc         <= sc_n;
         done_r     <= done_n;
      end
   end

   step_timer #(
      .W(PER_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .reload   (PER_W'(act.period - 1'b1)),
      .tick     (tmr_tick)
   );

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Directed bench for the stepper move sequencer.
// Cycle-stamped tick/done logs checked against hand timelines.
module tb_stepper_move_sequencer;

   localparam int HN = 2048;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [15:0] cmd_steps = '0;
   logic [15:0] cmd_period = '0;
   logic        abort = 1'b0;
   logic        motor_en, motor_dir, step_tick;
   logic        busy, done;
   logic [15:0] steps_left;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int tq[$];
   int dq[$];
   logic [15:0] h_sl  [HN];
   logic        h_en  [HN];
   logic        h_dir [HN];
   logic        h_rdy [HN];

   stepper_move_sequencer #(
      .STEP_W(16),
      .PER_W(16),
      .SETUP_CYC(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .abort      (abort),
      .motor_en   (motor_en),
      .motor_dir  (motor_dir),
      .step_tick  (step_tick),
      .busy       (busy),
      .done       (done),
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (step_tick) tq.push_back(cyc);
      if (done) dq.push_back(cyc);
      h_sl[cyc % HN]  <= steps_left;
      h_en[cyc % HN]  <= motor_en;
      h_dir[cyc % HN] <= motor_dir;
      h_rdy[cyc % HN] <= cmd_ready;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic d, input logic [15:0] s,
                       input logic [15:0] p, output int acc);
      acc = -1;
      cmd_valid = 1'b1;
      cmd_dir = d;
      cmd_steps = s;
      cmd_period = p;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      if (acc < 0) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got no accept want accept");
      end
   endtask

   task automatic clear_logs();
      tq.delete();
      dq.delete();
   endtask

   task automatic test_reset();
      int a;
      logic [15:0] o [7];
      logic [15:0] e [7];
      wait_cycles(2);
      rst = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || motor_en !== 1'b0) begin
         errors++;
         $display("FAIL por_state got rdy=%b busy=%b en=%b want 1 0 0",
                  cmd_ready, busy, motor_en);
      end
      wait_cycles(1);
      send(1'b1, 16'd10, 16'd5, a);
      wait_cycles(10);
      checks++;
      if (motor_en !== 1'b1 || steps_left === 16'd0) begin
         errors++;
         $display("FAIL rst_prerun got en=%b sl=%0d want en=1 sl>0",
                  motor_en, steps_left);
      end
      rst = 1'b1;
      #1;
      o = '{16'(motor_en), 16'(motor_dir), 16'(step_tick), 16'(done),
            16'(busy), steps_left, 16'(cmd_ready)};
      e = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (o[i] !== e[i]) begin
            errors++;
            $display("FAIL rst_out%0d got %0d want %0d", i, o[i], e[i]);
         end
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_cycles(1);
      checks++;
      if (cmd_ready !== 1'b1 || motor_en !== 1'b0) begin
         errors++;
         $display("FAIL rst_release got rdy=%b en=%b want 1 0",
                  cmd_ready, motor_en);
      end
   endtask

   task automatic test_single_move();
      int a;
      int et[3];
      int so[5];
      int se[5];
      clear_logs();
      send(1'b1, 16'd3, 16'd4, a);
      wait_cycles(22);
      et = '{a + 8, a + 12, a + 16};
      checks++;
      if (tq.size() != 3) begin
         errors++;
         $display("FAIL single_ntick got %0d want 3", tq.size());
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= tq.size() || tq[i] != et[i]) begin
            errors++;
            $display("FAIL single_tick%0d got %0d want %0d", i,
                     (i < tq.size()) ? tq[i] : -1, et[i]);
         end
      end
      checks++;
      if (dq.size() != 1 || dq[0] != a + 17) begin
         errors++;
         $display("FAIL single_done got n=%0d at %0d want n=1 at %0d",
                  dq.size(), (dq.size() > 0) ? dq[0] : -1, a + 17);
      end
      so = '{1, 8, 9, 13, 17};
      se = '{3, 3, 2, 1, 0};
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (h_sl[(a + so[i]) % HN] !== 16'(se[i])) begin
            errors++;
            $display("FAIL single_sl@+%0d got %0d want %0d", so[i],
                     h_sl[(a + so[i]) % HN], se[i]);
         end
      end
      checks++;
      if (h_en[a % HN] !== 1'b0 || h_en[(a + 1) % HN] !== 1'b1 ||
          h_en[(a + 16) % HN] !== 1'b1 || h_en[(a + 17) % HN] !== 1'b0) begin
         errors++;
         $display("FAIL single_en got %b%b%b%b want 0110",
                  h_en[a % HN], h_en[(a + 1) % HN],
                  h_en[(a + 16) % HN], h_en[(a + 17) % HN]);
      end
      checks++;
      if (h_dir[(a + 1) % HN] !== 1'b1) begin
         errors++;
         $display("FAIL single_dir got %b want 1", h_dir[(a + 1) % HN]);
      end
   endtask

   task automatic test_back_to_back();
      int a, b;
      int et[4];
      clear_logs();
      send(1'b0, 16'd2, 16'd3, a);
      send(1'b0, 16'd2, 16'd6, b);
      wait_cycles(26);
      et = '{a + 7, a + 10, a + 16, a + 22};
      checks++;
      if (b != a + 1 || tq.size() != 4) begin
         errors++;
         $display("FAIL b2b_setup got acc=%0d n=%0d want acc=%0d n=4",
                  b, tq.size(), a + 1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= tq.size() || tq[i] != et[i]) begin
            errors++;
            $display("FAIL b2b_tick%0d got %0d want %0d", i,
                     (i < tq.size()) ? tq[i] : -1, et[i]);
         end
      end
      checks++;
      if (dq.size() != 1 || dq[0] != a + 23) begin
         errors++;
         $display("FAIL b2b_done got n=%0d at %0d want n=1 at %0d",
                  dq.size(), (dq.size() > 0) ? dq[0] : -1, a + 23);
      end
      checks++;
      if (h_rdy[(a + 2) % HN] !== 1'b0 || h_rdy[(a + 11) % HN] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready got %b%b want 01",
                  h_rdy[(a + 2) % HN], h_rdy[(a + 11) % HN]);
      end
      checks++;
      if (h_en[(a + 11) % HN] !== 1'b1 || h_sl[(a + 11) % HN] !== 16'd2) begin
         errors++;
         $display("FAIL b2b_chain got en=%b sl=%0d want en=1 sl=2",
                  h_en[(a + 11) % HN], h_sl[(a + 11) % HN]);
      end
   endtask

   task automatic test_reversal();
      int a, b;
      clear_logs();
      send(1'b0, 16'd1, 16'd3, a);
      send(1'b1, 16'd1, 16'd3, b);
      wait_cycles(18);
      checks++;
      if (tq.size() != 2 || tq[0] != a + 7 || tq[1] != a + 14) begin
         errors++;
         $display("FAIL rev_ticks got n=%0d t0=%0d t1=%0d want 2 %0d %0d",
                  tq.size(), (tq.size() > 0) ? tq[0] : -1,
                  (tq.size() > 1) ? tq[1] : -1, a + 7, a + 14);
      end
      checks++;
      if (h_dir[(a + 7) % HN] !== 1'b0 || h_dir[(a + 8) % HN] !== 1'b1) begin
         errors++;
         $display("FAIL rev_dir got %b%b want 01",
                  h_dir[(a + 7) % HN], h_dir[(a + 8) % HN]);
      end
      checks++;
      if (h_rdy[(a + 2) % HN] !== 1'b0 || h_rdy[(a + 7) % HN] !== 1'b0 ||
          h_rdy[(a + 8) % HN] !== 1'b1) begin
         errors++;
         $display("FAIL rev_ready got %b%b%b want 001",
                  h_rdy[(a + 2) % HN], h_rdy[(a + 7) % HN],
                  h_rdy[(a + 8) % HN]);
      end
      checks++;
      if (dq.size() != 1 || dq[0] != a + 15 ||
          h_en[(a + 15) % HN] !== 1'b0) begin
         errors++;
         $display("FAIL rev_done got n=%0d at %0d want n=1 at %0d",
                  dq.size(), (dq.size() > 0) ? dq[0] : -1, a + 15);
      end
   endtask

   task automatic test_edges();
      int a;
      int et[3];
      clear_logs();
      send(1'b1, 16'd0, 16'd7, a);
      wait_cycles(4);
      checks++;
      if (tq.size() != 0 || dq.size() != 1 || dq[0] != a + 1) begin
         errors++;
         $display("FAIL zero_steps got ticks=%0d done=%0d want 0 1@%0d",
                  tq.size(), dq.size(), a + 1);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (h_en[(a + i) % HN] !== 1'b0) begin
            errors++;
            $display("FAIL zero_en@+%0d got 1 want 0", i);
         end
      end
      clear_logs();
      send(1'b1, 16'd3, 16'd0, a);
      wait_cycles(14);
      et = '{a + 6, a + 8, a + 10};
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= tq.size() || tq[i] != et[i]) begin
            errors++;
            $display("FAIL per0_tick%0d got %0d want %0d", i,
                     (i < tq.size()) ? tq[i] : -1, et[i]);
         end
      end
      checks++;
      if (dq.size() != 1 || dq[0] != a + 11) begin
         errors++;
         $display("FAIL per0_done got n=%0d want 1 at %0d",
                  dq.size(), a + 11);
      end
      clear_logs();
      send(1'b1, 16'd2, 16'd1, a);
      wait_cycles(12);
      checks++;
      if (tq.size() != 2 || tq[0] != a + 6 || tq[1] != a + 8) begin
         errors++;
         $display("FAIL per1_ticks got n=%0d t0=%0d want 2 %0d",
                  tq.size(), (tq.size() > 0) ? tq[0] : -1, a + 6);
      end
   endtask

   task automatic test_abort();
      int a, b;
      clear_logs();
      send(1'b1, 16'd3, 16'd4, a);
      send(1'b1, 16'd2, 16'd4, b);
      for (int i = 0; i < 100 && cyc < a + 12; i++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (cyc != a + 12 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_reach got cyc=%0d busy=%b want %0d 1",
                  cyc, busy, a + 12);
      end
      abort = 1'b1;
      #1;
      checks++;
      if (step_tick !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_same got tick=%b rdy=%b want 0 0",
                  step_tick, cmd_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (motor_en !== 1'b0 || steps_left !== 16'd0 ||
          busy !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_next got en=%b sl=%0d busy=%b rdy=%b want 0000",
                  motor_en, steps_left, busy, cmd_ready);
      end
      abort = 1'b0;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready got %b want 1", cmd_ready);
      end
      wait_cycles(20);
      checks++;
      if (tq.size() != 1 || tq[0] != a + 8 || dq.size() != 0) begin
         errors++;
         $display("FAIL abort_after got ticks=%0d done=%0d want 1 0",
                  tq.size(), dq.size());
      end
      checks++;
      if (motor_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got en=%b busy=%b want 0 0",
                  motor_en, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single_move();
      test_back_to_back();
      test_reversal();
      test_edges();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
